// File: rtl/riscv_multicycle_control.sv
// riscv_multicycle_control: main control FSM of the multi-cycle RV32I datapath (R, I-ALU, lw, sw, beq, jal).
// Build option MEM_WAIT_EN adds mem_ready and stalls FETCH, MEM_READ and MEM_WRITE until memory answers.
module riscv_multicycle_control #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       zero,
`ifdef MEM_WAIT_EN
    input  logic       mem_ready,
`endif
    output logic       ALUOp1,
    output logic       ALUOp0,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       PCSource,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] MemtoReg,
    output logic [3:0] state,
    output logic       illegal
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_ALU_WB    = 4'd7,
        S_I_EXEC    = 4'd8,
        S_BRANCH    = 4'd9,
        S_JAL       = 4'd10,
        S_ILLEGAL   = 4'd11
    } state_e;

    state_e     state_r;
    state_e     state_next_s;
    logic       mem_ok_s;
    logic [1:0] aluop_s;
    logic [1:0] srca_s;
    logic [1:0] srcb_s;
    logic       pcw_s;
    logic       pcwc_s;
    logic       pcsrc_s;
    logic       iord_s;
    logic       mr_s;
    logic       mw_s;
    logic       irw_s;
    logic       rw_s;
    logic [1:0] mtr_s;
    logic       ill_s;
    logic       unused_zero_s;

    // Branch resolution happens in the datapath; the sequence never looks at zero.
    assign unused_zero_s = zero;

`ifdef MEM_WAIT_EN
    assign mem_ok_s = mem_ready;
`else
    assign mem_ok_s = 1'b1;
`endif

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= state_e'(RESET_STATE);
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode; opcode is only consulted in DECODE and MEM_ADDR.
    always_comb begin
        state_next_s = S_FETCH;
        case (state_r)
            S_FETCH:     state_next_s = mem_ok_s ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_R:      state_next_s = S_R_EXEC;
                    OP_I:      state_next_s = S_I_EXEC;
                    OP_LOAD:   state_next_s = S_MEM_ADDR;
                    OP_STORE:  state_next_s = S_MEM_ADDR;
                    OP_BRANCH: state_next_s = S_BRANCH;
                    OP_JAL:    state_next_s = S_JAL;
                    default:   state_next_s = S_ILLEGAL;
                endcase
            end
            S_MEM_ADDR:  state_next_s = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  state_next_s = mem_ok_s ? S_MEM_WB : S_MEM_READ;
            S_MEM_WB:    state_next_s = S_FETCH;
            S_MEM_WRITE: state_next_s = mem_ok_s ? S_FETCH : S_MEM_WRITE;
            S_R_EXEC:    state_next_s = S_ALU_WB;
            S_I_EXEC:    state_next_s = S_ALU_WB;
            S_ALU_WB:    state_next_s = S_FETCH;
            S_BRANCH:    state_next_s = S_FETCH;
            S_JAL:       state_next_s = S_FETCH;
            S_ILLEGAL:   state_next_s = S_ILLEGAL;
            default:     state_next_s = S_FETCH;
        endcase
    end

    // Moore output decode; everything not named in a state stays 0.
    always_comb begin
        aluop_s = 2'b00;
        srca_s  = 2'b00;
        srcb_s  = 2'b00;
        pcw_s   = 1'b0;
        pcwc_s  = 1'b0;
        pcsrc_s = 1'b0;
        iord_s  = 1'b0;
        mr_s    = 1'b0;
        mw_s    = 1'b0;
        irw_s   = 1'b0;
        rw_s    = 1'b0;
        mtr_s   = 2'b00;
        ill_s   = 1'b0;
        case (state_r)
            S_FETCH: begin
                mr_s   = 1'b1;
                irw_s  = mem_ok_s;
                pcw_s  = mem_ok_s;
                srcb_s = 2'b01;
            end
            S_DECODE: begin
                srca_s = 2'b10;
                srcb_s = 2'b10;
            end
            S_MEM_ADDR: begin
                srca_s = 2'b01;
                srcb_s = 2'b10;
            end
            S_MEM_READ: begin
                mr_s   = 1'b1;
                iord_s = 1'b1;
            end
            S_MEM_WB: begin
                rw_s  = 1'b1;
                mtr_s = 2'b01;
            end
            S_MEM_WRITE: begin
                mw_s   = 1'b1;
                iord_s = 1'b1;
            end
            S_R_EXEC: begin
                srca_s  = 2'b01;
                aluop_s = 2'b10;
            end
            S_I_EXEC: begin
                srca_s  = 2'b01;
                srcb_s  = 2'b10;
                aluop_s = 2'b11;
            end
            S_ALU_WB:    rw_s = 1'b1;
            S_BRANCH: begin
                srca_s  = 2'b01;
                aluop_s = 2'b01;
                pcwc_s  = 1'b1;
                pcsrc_s = 1'b1;
            end
            S_JAL: begin
                pcw_s   = 1'b1;
                pcsrc_s = 1'b1;
                rw_s    = 1'b1;
                mtr_s   = 2'b10;
            end
            S_ILLEGAL:   ill_s = 1'b1;
            default:     ill_s = 1'b0;
        endcase
    end

    // Reset gates every strobe immediately so no write can slip through mid-instruction.
    assign {ALUOp1, ALUOp0, ALUSrcA, ALUSrcB, PCWrite, PCWriteCond, PCSource, IorD,
            MemRead, MemWrite, IRWrite, RegWrite, MemtoReg, illegal} =
        reset ? 17'd0 : {aluop_s, srca_s, srcb_s, pcw_s, pcwc_s, pcsrc_s, iord_s,
                         mr_s, mw_s, irw_s, rw_s, mtr_s, ill_s};

    assign state = state_r;

endmodule

// File: tb/tb_riscv_multicycle_control.sv
// Self-checking bench for riscv_multicycle_control: directed vector table, corner sequences and a
// randomized instruction stream compared against a per-instruction-class state-sequence model.
module tb_riscv_multicycle_control;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       zero;
    logic [6:0] opcode;
    logic       rdy_tb;
`ifdef MEM_WAIT_EN
    logic       mem_ready;
    assign rdy_tb = mem_ready;
`else
    assign rdy_tb = 1'b1;
`endif

    logic       ALUOp1, ALUOp0, PCWrite, PCWriteCond, PCSource, IorD;
    logic       MemRead, MemWrite, IRWrite, RegWrite, illegal;
    logic [1:0] ALUSrcA, ALUSrcB, MemtoReg;
    logic [3:0] state;

    riscv_multicycle_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
`ifdef MEM_WAIT_EN
        .mem_ready(mem_ready),
`endif
        .ALUOp1(ALUOp1), .ALUOp0(ALUOp0), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
        .MemtoReg(MemtoReg), .state(state), .illegal(illegal)
    );

    typedef struct packed {
        logic [1:0] aluop;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic       pcw;
        logic       pcwc;
        logic       pcsrc;
        logic       iord;
        logic       mr;
        logic       mw;
        logic       irw;
        logic       rw;
        logic [1:0] mtr;
        logic       ill;
    } outs_t;

    outs_t act;
    assign act = {ALUOp1, ALUOp0, ALUSrcA, ALUSrcB, PCWrite, PCWriteCond, PCSource, IorD,
                  MemRead, MemWrite, IRWrite, RegWrite, MemtoReg, illegal};

    typedef int seq_q[$];
    typedef struct {
        logic [6:0]  opc;
        logic        z;
        int          n;
        logic [31:0] seq;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Control word each state must present, taken from the state table.
    function automatic outs_t exp_out(input int st, input logic rdy);
        outs_t o;
        o = '0;
        case (st)
            0: begin o.mr = 1'b1; o.irw = rdy; o.pcw = rdy; o.srcb = 2'b01; end
            1: begin o.srca = 2'b10; o.srcb = 2'b10; end
            2: begin o.srca = 2'b01; o.srcb = 2'b10; end
            3: begin o.mr = 1'b1; o.iord = 1'b1; end
            4: begin o.rw = 1'b1; o.mtr = 2'b01; end
            5: begin o.mw = 1'b1; o.iord = 1'b1; end
            6: begin o.srca = 2'b01; o.aluop = 2'b10; end
            7: o.rw = 1'b1;
            8: begin o.srca = 2'b01; o.srcb = 2'b10; o.aluop = 2'b11; end
            9: begin o.srca = 2'b01; o.aluop = 2'b01; o.pcwc = 1'b1; o.pcsrc = 1'b1; end
            10: begin o.pcw = 1'b1; o.pcsrc = 1'b1; o.rw = 1'b1; o.mtr = 2'b10; end
            11: o.ill = 1'b1;
            default: o = '0;
        endcase
        return o;
    endfunction

    // Instruction class -> visited states from FETCH until the next FETCH.
    function automatic seq_q path(input logic [6:0] op);
        seq_q q;
        q.push_back(0);
        q.push_back(1);
        case (op)
            7'b0110011: begin q.push_back(6); q.push_back(7); end
            7'b0010011: begin q.push_back(8); q.push_back(7); end
            7'b0000011: begin q.push_back(2); q.push_back(3); q.push_back(4); end
            7'b0100011: begin q.push_back(2); q.push_back(5); end
            7'b1100011: q.push_back(9);
            7'b1101111: q.push_back(10);
            default: begin q.push_back(11); q.push_back(11); q.push_back(11); end
        endcase
        return q;
    endfunction

    task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, a, e);
        end
    endtask

    task automatic check_cycle(input string tag, input int st);
        check({tag, ".state"}, 32'(state), 32'(st));
        check({tag, ".outs"}, 32'(act), 32'(exp_out(st, rdy_tb)));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Applies reset for one edge from wherever the FSM is and checks the gating and return to FETCH.
    task automatic reset_pulse(input string tag);
        reset = 1'b1;
        #1;
        check({tag, ".rst_gate"}, 32'(act), 32'd0);
        step();
        check({tag, ".rst_state"}, 32'(state), 32'd0);
        check({tag, ".rst_outs"}, 32'(act), 32'd0);
        reset = 1'b0;
    endtask

    vec_t vecs[8];

    initial begin
        seq_q q;
        int   inj;
        bit   aborted;
        int   st;
        logic [6:0] opc;

        vecs[0] = '{7'b0110011, 1'b0, 4, 32'h0000_7610};
        vecs[1] = '{7'b0000011, 1'b0, 5, 32'h0004_3210};
        vecs[2] = '{7'b0100011, 1'b1, 4, 32'h0000_5210};
        vecs[3] = '{7'b1100011, 1'b0, 3, 32'h0000_0910};
        vecs[4] = '{7'b1100011, 1'b1, 3, 32'h0000_0910};
        vecs[5] = '{7'b0010011, 1'b0, 4, 32'h0000_7810};
        vecs[6] = '{7'b1101111, 1'b1, 3, 32'h0000_0A10};
        vecs[7] = '{7'b1111111, 1'b0, 8, 32'hBBBB_BB10};

        reset  = 1'b1;
        zero   = 1'b0;
        opcode = 7'd0;
`ifdef MEM_WAIT_EN
        mem_ready = 1'b1;
`endif
        step();
        check("rst1.state", 32'(state), 32'd0);
        check("rst1.outs", 32'(act), 32'd0);
        step();
        check("rst2.state", 32'(state), 32'd0);
        check("rst2.outs", 32'(act), 32'd0);
        reset = 1'b0;
        #1;
        check_cycle("first_fetch", 0);

        // Directed vector table: each entry starts in FETCH.
        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < vecs[v].n; i++) begin
                st = int'(vecs[v].seq[4*i +: 4]);
                opcode = (st == 1 || st == 2) ? vecs[v].opc : 7'($urandom);
                zero = vecs[v].z;
                #1;
                check_cycle($sformatf("vec%0d.c%0d", v, i), st);
                step();
            end
            if (vecs[v].seq[4*(vecs[v].n-1) +: 4] == 4'hB) begin
                check($sformatf("vec%0d.hold", v), 32'(state), 32'd11);
                reset_pulse($sformatf("vec%0d", v));
            end
            #1;
            check($sformatf("vec%0d.back", v), 32'(state), 32'd0);
        end

        // Reset arriving in MEM_READ must kill the read at once.
        q = path(7'b0000011);
        for (int i = 0; i < 4; i++) begin
            opcode = 7'b0000011;
            #1;
            check_cycle($sformatf("lw_abort.c%0d", i), q[i]);
            if (i < 3) step();
        end
        check("lw_abort.mr_before", 32'(MemRead), 32'd1);
        reset_pulse("lw_abort");
        #1;

`ifdef MEM_WAIT_EN
        // Fetch stall: PC and IR must load exactly once, on the ready cycle.
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("wait.state%0d", i), 32'(state), 32'd0);
            check($sformatf("wait.pcw%0d", i), 32'(PCWrite), 32'd0);
            check_cycle($sformatf("wait.c%0d", i), 0);
            step();
        end
        mem_ready = 1'b1;
        #1;
        check("wait.pcw_go", 32'(PCWrite), 32'd1);
        step();
        check("wait.decode", 32'(state), 32'd1);
        check("wait.pcw_after", 32'(PCWrite), 32'd0);
        reset_pulse("wait");
        #1;
`endif

        // Randomized instruction stream with occasional mid-instruction reset.
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 6))
                0: opc = 7'b0110011;
                1: opc = 7'b0010011;
                2: opc = 7'b0000011;
                3: opc = 7'b0100011;
                4: opc = 7'b1100011;
                5: opc = 7'b1101111;
                default: opc = 7'($urandom);
            endcase
            q = path(opc);
            inj = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, q.size() - 1)) : -1;
            aborted = 1'b0;
            for (int i = 0; i < q.size(); i++) begin
                opcode = (q[i] == 1 || q[i] == 2) ? opc : 7'($urandom);
                zero = 1'($urandom);
                #1;
                check_cycle($sformatf("rnd%0d.c%0d", n, i), q[i]);
                if (i == inj) begin
                    reset_pulse($sformatf("rnd%0d", n));
                    aborted = 1'b1;
                    break;
                end
                step();
            end
            if (!aborted && q[q.size()-1] == 11) begin
                check($sformatf("rnd%0d.hold", n), 32'(state), 32'd11);
                reset_pulse($sformatf("rnd%0d.ill", n));
            end
        end
        #1;
        check("final.state", 32'(state), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/riscv_multicycle_control.md
Name: riscv_multicycle_control

Overview:
- Main control FSM for the multi-cycle RV32I datapath.
- Decodes the 7-bit opcode over successive clock cycles and drives the datapath strobes and muxes.
- Produces the ALUOp1/ALUOp0 pair consumed by the ALU control decoder, which combines it with funct7/funct3 to form the 4-bit ALU operation.
- Subset handled: R-type, I-type ALU, lw, sw, beq, jal.

Parameters:
- RESET_STATE, 4'd0, state register value loaded on reset (FETCH).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high.
- opcode  input  7  instruction[6:0] from the instruction register.
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory handshake; present only with MEM_WAIT_EN.
- ALUOp1, ALUOp0  output  1 each  to ALU control: 00 add, 01 subtract, 10 R-type funct decode, 11 I-type funct decode.
- ALUSrcA  output  2  00 PC, 01 rs1, 10 oldPC.
- ALUSrcB  output  2  00 rs2, 01 constant 4, 10 immediate.
- PCWrite  output  1  unconditional PC load.
- PCWriteCond  output  1  PC load if zero=1.
- PCSource  output  1  0 ALU result, 1 ALUOut register.
- IorD  output  1  memory address: 0 PC, 1 ALUOut.
- MemRead, MemWrite, IRWrite, RegWrite  output  1 each  strobes.
- MemtoReg  output  2  writeback source: 00 ALUOut, 01 MDR, 10 PC.
- state  output  4  current state, for debug/verification.
- illegal  output  1  unsupported opcode trapped.

Behaviour:
- One clock; reset is synchronous and active-high. Ports are named clk and reset.
- Reset behaviour:
  - Any rising edge with reset=1 loads state=FETCH, including mid-instruction.
  - While reset=1, every output except state is forced to 0 combinationally, so no writes occur.
- Moore machine: outputs are a pure function of state. Unlisted outputs are 0.
- State encodings, outputs and transitions:
  - 0 FETCH: MemRead, IRWrite, IorD=0, ALUSrcA=00, ALUSrcB=01, ALUOp=00, PCWrite, PCSource=0. Next: DECODE.
  - 1 DECODE: ALUSrcA=10, ALUSrcB=10, ALUOp=00 (branch/jump target into ALUOut). Next by opcode:
    - 0110011 → R_EXEC
    - 0010011 → I_EXEC
    - 0000011 or 0100011 → MEM_ADDR
    - 1100011 → BRANCH
    - 1101111 → JAL
    - any other → ILLEGAL
  - 2 MEM_ADDR: ALUSrcA=01, ALUSrcB=10, ALUOp=00. Next: MEM_READ if opcode=0000011, else MEM_WRITE.
  - 3 MEM_READ: MemRead, IorD=1. Next: MEM_WB.
  - 4 MEM_WB: RegWrite, MemtoReg=01. Next: FETCH.
  - 5 MEM_WRITE: MemWrite, IorD=1. Next: FETCH.
  - 6 R_EXEC: ALUSrcA=01, ALUSrcB=00, ALUOp=10. Next: ALU_WB.
  - 8 I_EXEC: ALUSrcA=01, ALUSrcB=10, ALUOp=11. Next: ALU_WB.
  - 7 ALU_WB: RegWrite, MemtoReg=00. Next: FETCH.
  - 9 BRANCH: ALUSrcA=01, ALUSrcB=00, ALUOp=01, PCWriteCond, PCSource=1. Next: FETCH. The PC update is decided by the datapath from zero; the FSM path does not depend on zero.
  - 10 JAL: PCWrite, PCSource=1, RegWrite, MemtoReg=10 (PC already holds PC+4). Next: FETCH.
  - 11 ILLEGAL: illegal=1, all strobes 0. Holds until reset.
  - 12–15 (unreachable): all outputs 0. Next: FETCH.
- opcode is sampled only in DECODE and MEM_ADDR. The IR is stable in both, since IRWrite is asserted only in FETCH.
- Cycles per instruction, FETCH entry to next FETCH: R/I/sw 4, lw 5, beq 3, jal 3.

Optional Feature:
- Macro: MEM_WAIT_EN.
- Defined:
  - mem_ready port exists.
  - FETCH, MEM_READ and MEM_WRITE hold their state and outputs while mem_ready=0, and advance on the first edge with mem_ready=1.
  - IRWrite and PCWrite in FETCH are asserted only when mem_ready=1, so the PC increments exactly once.
  - reset still overrides a wait.
- Undefined: no mem_ready port; memory is treated as single-cycle and the state sequence is exactly as listed above.

Test Plan:
- reset=1 for 2 cycles, then release → state=0 with all strobes 0 during reset; first cycle after release shows MemRead=1, IRWrite=1, PCWrite=1, ALUOp=00.
- opcode=0110011 → states 0,1,6,7,0; in state 6 ALUOp1=1, ALUOp0=0, ALUSrcB=00; RegWrite=1 only in state 7.
- opcode=0000011 then 0100011 → lw: 0,1,2,3,4,0 with MemtoReg=01 in 4; sw: 0,1,2,5,0 with MemWrite=1 and IorD=1 only in 5.
- opcode=1100011, zero toggled 0 and 1 → 0,1,9,0 in both cases; in 9 ALUOp=01, PCWriteCond=1, PCWrite=0. opcode=0010011 → state 8 has ALUOp=11.
- opcode=1111111 → 0,1,11, illegal=1 held for 5+ cycles; reset=1 → state 0 next edge, illegal=0. Assert reset while in state 3 → next state 0 and MemRead=0 during reset.
- MEM_WAIT_EN defined, mem_ready=0 for 3 cycles in FETCH → state stays 0 and PCWrite=0; raise mem_ready → PCWrite=1 for exactly one cycle, then DECODE.
